// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and default widths.
// Used by the fetch sequencer, its bus interface and later pipeline stages.
package cpu_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int DEF_PC_W    = 32;
  localparam int DEF_INSTR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch bus: instruction-memory address/data plus the valid/ready decode handoff.
// master = fetch sequencer, slave = memory model / decode side.
interface fetch_sequencer_if
  import cpu_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W
);

  logic [PC_W-1:0]    imem_pc;
  logic [INSTR_W-1:0] imem_instr;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_valid;
  logic               instr_ready;

  modport master (
    output imem_pc,
    input  imem_instr,
    output instr,
    output instr_pc,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  imem_pc,
    output imem_instr,
    input  instr,
    input  instr_pc,
    input  instr_valid,
    output instr_ready
  );

endinterface

// File: rtl/fetch_sequencer_out_reg.sv
// One-entry valid/ready output register with flush; loads in the cycle after acceptance.
// Accepts new data while empty or while the held entry drains; flush drops the entry and any load.
module fetch_out_reg #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         in_vld_i,
  input  logic [W-1:0] in_dat_i,
  output logic         in_rdy_o,
  output logic         out_vld_o,
  output logic [W-1:0] out_dat_o,
  input  logic         out_rdy_i
);

  logic         vld_q, vld_d;
  logic [W-1:0] dat_q, dat_d;

  assign in_rdy_o  = !vld_q || out_rdy_i;
  assign out_vld_o = vld_q;
  assign out_dat_o = dat_q;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (flush_i) begin
      vld_d = 1'b0;
    end else if (in_vld_i && in_rdy_o) begin
      vld_d = 1'b1;
      dat_d = in_dat_i;
    end else if (out_rdy_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, reads the single-cycle imem, and hands words to decode.
// First word valid two edges after start; stalls PC and output while decode withholds ready.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W      = DEF_PC_W,
  parameter int              INSTR_W   = DEF_INSTR_W,
  parameter int              NUM_INSTR = 9,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_target,
  fetch_sequencer_if.master bus,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [PC_W-1:0] END_PC = PC_W'(NUM_INSTR * INSTR_BYTES);
  localparam logic [PC_W-1:0] STEP   = PC_W'(INSTR_BYTES);

  fetch_state_t            state_q, state_d;
  logic [PC_W-1:0]         pc_q, pc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PC_W-1:0]         pc_plus, br_pc;
  logic                    flush, load, cap, hs;
  logic [PC_W+INSTR_W-1:0] out_dat;
  logic                    unused_tgt_lsb;

  assign unused_tgt_lsb = ^branch_target[1:0];

  assign pc_plus = pc_q + STEP;
  assign br_pc   = {branch_target[PC_W-1:2], 2'b00};
  assign hs      = bus.instr_valid && bus.instr_ready;
  // Restart and redirect both invalidate whatever decode has not yet taken.
  assign flush   = start || (branch_taken && (state_q != ST_IDLE));
  assign load    = (state_q == ST_FETCH) && !flush;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (start) begin
      state_d = ST_FETCH;
      pc_d    = RESET_PC;
    end else if (branch_taken && (state_q != ST_IDLE)) begin
      pc_d    = br_pc;
      state_d = (br_pc < END_PC) ? ST_FETCH : ST_HALT;
    end else if (load && cap) begin
      pc_d = pc_plus;
      if (pc_plus >= END_PC) begin
        state_d = ST_HALT;
      end
    end
    cnt_d = (hs && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  fetch_out_reg #(
    .W(PC_W + INSTR_W)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .flush_i   (flush),
    .in_vld_i  (load),
    .in_dat_i  ({pc_q, bus.imem_instr}),
    .in_rdy_o  (cap),
    .out_vld_o (bus.instr_valid),
    .out_dat_o (out_dat),
    .out_rdy_i (bus.instr_ready)
  );

  // pc_q only ever leaves RESET_PC after start, so it doubles as the IDLE address.
  assign bus.imem_pc              = pc_q;
  assign {bus.instr_pc, bus.instr} = out_dat;
  assign busy                     = (state_q == ST_FETCH);
  assign halted                   = (state_q == ST_HALT) && !bus.instr_valid;
  assign fetch_count              = cnt_q;

endmodule
